rvm_mem_arbiter: RTL and testbench

// - Shares the core's single memory bus (m_*) between two requesters: instruction fetch (i_*) and load/store data (d_*).
// - Sits between rvm_control (which raises i_req / d_req per FSM state) and the external memory interface.
// - One outstanding transaction at a time. Round-robin when both request.
// - Per-port response data and error are registered and held, so the control FSM may sample them in any later cycle.

---
 rtl/rvm_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_rvm_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvm_mem_arbiter.sv
// Two-port memory bus arbiter: instruction fetch and load/store share one bus, with
// one outstanding transaction, round-robin on ties, and held per-port response data.
module rvm_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  // Instruction fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rsp,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_error,
  // Load/store data port
  input  logic                d_req,
  input  logic                d_wen,
  input  logic [DATA_W/8-1:0] d_strb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rsp,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_error,
  // Memory bus
  output logic                m_req,
  output logic                m_wen,
  output logic [DATA_W/8-1:0] m_strb,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_gnt,
  input  logic                m_rsp,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_error,
  output logic                busy
);

  localparam int unsigned StrbW = DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 0 = fetch, 1 = data
  logic                last_q, last_d;    // port most recently granted
  logic                m_wen_q, m_wen_d;
  logic [StrbW-1:0]    m_strb_q, m_strb_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic                i_error_q, i_error_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                d_error_q, d_error_d;

  logic idle;
  logic gnt_fetch;
  logic gnt_data;
  logic complete;

  // On a tie the port that was not granted last wins.
  assign idle      = (state_q == StIdle);
  assign gnt_fetch = idle & i_req & (~d_req | last_q);
  assign gnt_data  = idle & d_req & (~i_req | ~last_q);
  assign complete  = ((state_q == StReq) & m_gnt & m_rsp) | ((state_q == StWait) & m_rsp);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    m_wen_d   = m_wen_q;
    m_strb_d  = m_strb_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    i_error_d = i_error_q;
    d_rdata_d = d_rdata_q;
    d_error_d = d_error_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_fetch || gnt_data) begin
          state_d = StReq;
          owner_d = gnt_data;
          last_d  = gnt_data;
          if (gnt_data) begin
            m_wen_d   = d_wen;
            m_strb_d  = d_strb;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
          end else begin
            m_wen_d   = 1'b0;
            m_strb_d  = '1;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
          end
        end
      end
      StReq: begin
        if (m_gnt) begin
          state_d = m_rsp ? StIdle : StWait;
        end
      end
      StWait: begin
        if (m_rsp) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Only the owning port captures the response; the other keeps its last result.
    if (complete) begin
      if (owner_q) begin
        d_rdata_d = m_rdata;
        d_error_d = m_error;
      end else begin
        i_rdata_d = m_rdata;
        i_error_d = m_error;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      m_wen_q   <= 1'b0;
      m_strb_q  <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      i_error_q <= 1'b0;
      d_rdata_q <= '0;
      d_error_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      m_wen_q   <= m_wen_d;
      m_strb_q  <= m_strb_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      i_error_q <= i_error_d;
      d_rdata_q <= d_rdata_d;
      d_error_q <= d_error_d;
    end
  end

  assign i_gnt   = gnt_fetch;
  assign d_gnt   = gnt_data;
  assign i_rsp   = complete & ~owner_q;
  assign d_rsp   = complete & owner_q;
  assign i_rdata = i_rdata_q;
  assign i_error = i_error_q;
  assign d_rdata = d_rdata_q;
  assign d_error = d_error_q;

  assign m_req   = (state_q == StReq);
  assign busy    = (state_q != StIdle);
  assign m_wen   = m_wen_q;
  assign m_strb  = m_strb_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_rvm_mem_arbiter.sv
// Bench for rvm_mem_arbiter: directed cycle table, tie/reset sequences and a randomized
// run checked against a transaction-level reference model.
module tb_rvm_mem_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_gnt, i_rsp, i_error;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_wen, d_gnt, d_rsp, d_error;
  logic [3:0]  d_strb;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_wen, m_gnt, m_rsp, m_error, busy;
  logic [3:0]  m_strb;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  rvm_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rsp(i_rsp),
    .i_rdata(i_rdata), .i_error(i_error),
    .d_req(d_req), .d_wen(d_wen), .d_strb(d_strb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rsp(d_rsp), .d_rdata(d_rdata), .d_error(d_error),
    .m_req(m_req), .m_wen(m_wen), .m_strb(m_strb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rsp(m_rsp), .m_rdata(m_rdata), .m_error(m_error),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // {gnt i,d; rsp i,d; m_req; busy; m_wen; m_strb; m_addr; m_wdata; i_err; i_rdata; d_err; d_rdata}
  logic [140:0] obs;
  assign obs = {i_gnt, d_gnt, i_rsp, d_rsp, m_req, busy, m_wen, m_strb, m_addr, m_wdata,
                i_error, i_rdata, d_error, d_rdata};

  typedef struct packed {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwen;
    logic [3:0]  dstrb;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        mgnt;
    logic        mrsp;
    logic [31:0] mrdata;
    logic        merr;
  } in_t;

  typedef struct packed {
    in_t          in;
    logic [140:0] exp;
  } vec_t;

  vec_t vt[21];

  task automatic check_vec(input string name, input logic [140:0] act, input logic [140:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic in_t vin(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                              input logic dwen, input logic [3:0] dstrb,
                              input logic [31:0] daddr, input logic [31:0] dwdata,
                              input logic mgnt, input logic mrsp, input logic [31:0] mrdata,
                              input logic merr);
    return {ireq, iaddr, dreq, dwen, dstrb, daddr, dwdata, mgnt, mrsp, mrdata, merr};
  endfunction

  function automatic logic [140:0] vexp(input logic [1:0] gnt, input logic [1:0] rsp,
                                        input logic mreq, input logic bsy, input logic mwen,
                                        input logic [3:0] mstrb, input logic [31:0] maddr,
                                        input logic [31:0] mwdata, input logic ierr,
                                        input logic [31:0] irdata, input logic derr,
                                        input logic [31:0] drdata);
    return {gnt, rsp, mreq, bsy, mwen, mstrb, maddr, mwdata, ierr, irdata, derr, drdata};
  endfunction

  task automatic apply(input in_t x);
    i_req   = x.ireq;  i_addr  = x.iaddr;
    d_req   = x.dreq;  d_wen   = x.dwen;  d_strb = x.dstrb;
    d_addr  = x.daddr; d_wdata = x.dwdata;
    m_gnt   = x.mgnt;  m_rsp   = x.mrsp;  m_rdata = x.mrdata; m_error = x.merr;
  endtask

  task automatic idle_inputs();
    apply(vin(L, 0, L, L, 4'h0, 0, 0, L, L, 0, L));
  endtask

  // Leaves the bench at posedge+1 with reset released and all inputs idle.
  task automatic do_reset();
    idle_inputs();
    reset = H;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = L;
  endtask

  // Transaction-level reference model state.
  int          cur;          // owning port of the open transaction, -1 when none
  bit          acc;          // bus has accepted the open transaction
  int          last;
  logic        p_wen;
  logic [3:0]  p_strb;
  logic [31:0] p_addr, p_wdata;
  logic [31:0] rd_m[2];
  logic        er_m[2];

  task automatic model_reset();
    cur = -1; acc = 0; last = 1;
    p_wen = 0; p_strb = 0; p_addr = 0; p_wdata = 0;
    rd_m[0] = 0; rd_m[1] = 0; er_m[0] = 0; er_m[1] = 0;
  endtask

  initial begin
    localparam logic [31:0] Db = 32'hDEADBEEF;
    idle_inputs();
    reset = H;
    @(negedge clk);
    check_vec("reset_state", obs, '0);
    @(posedge clk); #1;
    reset = L;

    // Directed cycle table: single fetch, store with same-cycle completion, error read.
    vt[0]  = '{vin(H, 32'h100, L, L, 4'h0, 0, 0, L, L, 0, L),
               vexp(2'b10, 2'b00, L, L, L, 4'h0, 0, 0, L, 0, L, 0)};
    vt[1]  = '{vin(L, 0, L, L, 4'h0, 0, 0, L, L, 0, L),
               vexp(2'b00, 2'b00, H, H, L, 4'hF, 32'h100, 0, L, 0, L, 0)};
    vt[2]  = vt[1];
    vt[3]  = '{vin(L, 0, L, L, 4'h0, 0, 0, H, L, 0, L),
               vexp(2'b00, 2'b00, H, H, L, 4'hF, 32'h100, 0, L, 0, L, 0)};
    vt[4]  = '{vin(L, 0, L, L, 4'h0, 0, 0, L, L, 0, L),
               vexp(2'b00, 2'b00, L, H, L, 4'hF, 32'h100, 0, L, 0, L, 0)};
    vt[5]  = vt[4];
    vt[6]  = '{vin(L, 0, L, L, 4'h0, 0, 0, L, H, Db, L),
               vexp(2'b00, 2'b10, L, H, L, 4'hF, 32'h100, 0, L, 0, L, 0)};
    vt[7]  = '{vin(L, 0, L, L, 4'h0, 0, 0, L, L, 0, L),
               vexp(2'b00, 2'b00, L, L, L, 4'hF, 32'h100, 0, L, Db, L, 0)};
    vt[8]  = '{vin(L, 0, L, L, 4'h0, 0, 0, L, H, 32'h55, L),
               vexp(2'b00, 2'b00, L, L, L, 4'hF, 32'h100, 0, L, Db, L, 0)};
    vt[9]  = '{vin(L, 0, H, H, 4'h3, 32'h2000, 32'h1234, L, L, 0, L),
               vexp(2'b01, 2'b00, L, L, L, 4'hF, 32'h100, 0, L, Db, L, 0)};
    vt[10] = '{vin(L, 0, L, L, 4'h0, 0, 0, H, H, 32'hAAAA, L),
               vexp(2'b00, 2'b01, H, H, H, 4'h3, 32'h2000, 32'h1234, L, Db, L, 0)};
    vt[11] = '{vin(L, 0, L, L, 4'h0, 0, 0, L, L, 0, L),
               vexp(2'b00, 2'b00, L, L, H, 4'h3, 32'h2000, 32'h1234, L, Db, L, 32'hAAAA)};
    vt[12] = '{vin(L, 0, L, L, 4'h0, 0, 0, L, H, 32'h66, H),
               vexp(2'b00, 2'b00, L, L, H, 4'h3, 32'h2000, 32'h1234, L, Db, L, 32'hAAAA)};
    vt[13] = '{vin(L, 0, H, L, 4'hF, 32'h3000, 0, L, L, 0, L),
               vexp(2'b01, 2'b00, L, L, H, 4'h3, 32'h2000, 32'h1234, L, Db, L, 32'hAAAA)};
    vt[14] = '{vin(L, 0, L, L, 4'h0, 0, 0, H, L, 0, L),
               vexp(2'b00, 2'b00, H, H, L, 4'hF, 32'h3000, 0, L, Db, L, 32'hAAAA)};
    vt[15] = '{vin(L, 0, L, L, 4'h0, 0, 0, L, H, 32'hBAD, H),
               vexp(2'b00, 2'b01, L, H, L, 4'hF, 32'h3000, 0, L, Db, L, 32'hAAAA)};
    vt[16] = '{vin(L, 0, L, L, 4'h0, 0, 0, L, L, 0, L),
               vexp(2'b00, 2'b00, L, L, L, 4'hF, 32'h3000, 0, L, Db, H, 32'hBAD)};
    vt[17] = vt[16];
    vt[18] = '{vin(L, 0, H, L, 4'hF, 32'h3004, 0, L, L, 0, L),
               vexp(2'b01, 2'b00, L, L, L, 4'hF, 32'h3000, 0, L, Db, H, 32'hBAD)};
    vt[19] = '{vin(L, 0, L, L, 4'h0, 0, 0, H, H, 32'h77, L),
               vexp(2'b00, 2'b01, H, H, L, 4'hF, 32'h3004, 0, L, Db, H, 32'hBAD)};
    vt[20] = '{vin(L, 0, L, L, 4'h0, 0, 0, L, L, 0, L),
               vexp(2'b00, 2'b00, L, L, L, 4'hF, 32'h3004, 0, L, Db, L, 32'h77)};

    for (int k = 0; k < 21; k++) begin
      apply(vt[k].in);
      @(negedge clk);
      check_vec($sformatf("table[%0d]", k), obs, vt[k].exp);
      @(posedge clk); #1;
    end

    // Tie after reset: grants alternate fetch, data, fetch, data; never both.
    begin
      int n = 0;
      int both = 0;
      int exp_port = 0;
      do_reset();
      apply(vin(H, 32'h40, H, L, 4'hF, 32'h80, 0, H, H, 32'h1, L));
      for (int c = 0; c < 40 && n < 4; c++) begin
        @(negedge clk);
        if (i_gnt && d_gnt) both++;
        if (i_gnt || d_gnt) begin
          check32($sformatf("tie_order[%0d]", n), {31'b0, d_gnt}, exp_port);
          exp_port ^= 1;
          n++;
        end
        @(posedge clk); #1;
      end
      check32("tie_count", n, 4);
      check32("tie_both_gnt", both, 0);
    end

    // Reset while in REQ: m_req and busy drop without waiting for a clock edge.
    do_reset();
    apply(vin(H, 32'h500, L, L, 4'h0, 0, 0, L, L, 0, L));
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check32("req_before_reset", {30'b0, m_req, busy}, 32'h3);
    reset = H;
    #1;
    check32("req_async_reset", {30'b0, m_req, busy}, 32'h0);
    @(posedge clk); #1;
    reset = L;

    // Reset while in WAIT, then a stale m_rsp two cycles after release.
    apply(vin(H, 32'h600, L, L, 4'h0, 0, 0, L, L, 0, L));
    @(posedge clk); #1;
    apply(vin(L, 0, L, L, 4'h0, 0, 0, H, L, 0, L));
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check32("wait_before_reset", {30'b0, m_req, busy}, 32'h1);
    reset = H;
    #1;
    check32("wait_async_reset", {30'b0, m_req, busy}, 32'h0);
    @(posedge clk); #1;
    reset = L;
    @(posedge clk); #1;
    @(posedge clk); #1;
    apply(vin(L, 0, L, L, 4'h0, 0, 0, L, H, 32'h99, H));
    @(negedge clk);
    check32("stale_rsp_dropped", {30'b0, i_rsp, d_rsp}, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    check32("stale_i_rdata", i_rdata, 32'h0);
    check32("stale_d_rdata", d_rdata, 32'h0);
    check32("stale_err_busy", {29'b0, i_error, d_error, busy}, 32'h0);

    // Randomized traffic against the transaction-level model.
    begin
      bit          ip, dp;
      logic [31:0] ia, da, dw;
      logic        dwn;
      logic [3:0]  ds;
      do_reset();
      model_reset();
      ip = 0; dp = 0; ia = 0; da = 0; dw = 0; dwn = 0; ds = 0;
      for (int c = 0; c < 3000; c++) begin
        logic       gi, gd, ri, rdn, mrq, done;
        int         g;
        if (!ip && $urandom_range(0, 2) == 0) begin
          ip = 1; ia = $urandom;
        end
        if (!dp && $urandom_range(0, 2) == 0) begin
          dp = 1; da = $urandom; dw = $urandom; dwn = 1'($urandom_range(0, 1));
          ds = 4'($urandom_range(0, 15));
        end
        apply(vin(ip, ia, dp, dwn, ds, da, dw, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 3) == 0)));

        // Expected outputs for this cycle.
        g = -1;
        if (cur < 0) begin
          if (ip && dp) g = (last == 0) ? 1 : 0;
          else if (ip) g = 0;
          else if (dp) g = 1;
        end
        gi   = (g == 0);
        gd   = (g == 1);
        mrq  = (cur >= 0) && !acc;
        done = (cur >= 0) && m_rsp && (acc || m_gnt);
        ri   = done && (cur == 0);
        rdn  = done && (cur == 1);
        @(negedge clk);
        check_vec($sformatf("random[%0d]", c), obs,
                  vexp({gi, gd}, {ri, rdn}, mrq, cur >= 0, p_wen, p_strb, p_addr, p_wdata,
                       er_m[0], rd_m[0], er_m[1], rd_m[1]));

        // Advance the model across the coming edge.
        if (g == 0) begin
          cur = 0; last = 0; acc = 0; ip = 0;
          p_wen = 0; p_strb = 4'hF; p_addr = ia; p_wdata = 0;
        end else if (g == 1) begin
          cur = 1; last = 1; acc = 0; dp = 0;
          p_wen = dwn; p_strb = ds; p_addr = da; p_wdata = dw;
        end else if (done) begin
          rd_m[cur] = m_rdata; er_m[cur] = m_error; cur = -1;
        end else if (cur >= 0 && m_gnt) begin
          acc = 1;
        end
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
